// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the video blitter.
// Frame is 128x128 words; the control-register window sits at mem_addr[15]=1.
package video_pkg;

  localparam logic [15:0] CR_BASE_ADDR = 16'h8000;
  localparam int          FB_DIM       = 128;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_FLIP = 2'd2,
    OP_RSVD = 2'd3
  } blit_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_COPY_RD = 3'd2,
    ST_COPY_WR = 3'd3,
    ST_FLIP    = 3'd4,
    ST_DONE    = 3'd5
  } blit_state_t;

  // Clamp a run length so that pos + len never passes the frame edge.
  function automatic logic [7:0] clip_extent(input logic [7:0] len, input logic [6:0] pos);
    logic [7:0] room;
    room = 8'(FB_DIM) - {1'b0, pos};
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/video_blitter_rect_scanner.sv
// rect_scanner: walks a clipped rectangle in row-major order.
// Latches the effective width/height on load, then steps col (then row) on
// every advance and flags the final pixel so the FSM knows when to stop.
module rect_scanner
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] ew_in,
  input  logic [7:0] eh_in,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic       last
);

  logic [7:0] ew;
  logic [7:0] eh;

  // Latch the extent on load, otherwise step column-first through the rectangle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ew  <= 8'd0;
      eh  <= 8'd0;
      col <= 8'd0;
      row <= 8'd0;
    end else if (load) begin
      ew  <= ew_in;
      eh  <= eh_in;
      col <= 8'd0;
      row <= 8'd0;
    end else if (advance) begin
      if (col == ew - 8'd1) begin
        col <= 8'd0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  assign last = (col == ew - 8'd1) && (row == eh - 8'd1);

endmodule

// File: rtl/video_blitter.sv
// video_blitter: turns FILL / COPY / FLIP commands into bus cycles on the
// video unit's memory/control port (clk is the video unit's mem_clk).
// Optional build macro VIDEO_BLITTER_COLORKEY_EN: COPY skips writing any
// source pixel whose low 24 bits equal the command colour.
// Bus outputs are registered from the current state, so each state's bus
// cycle appears one clock after the FSM enters it. The one exception is the
// COPY write: its data (and, with colour keying, its enable) comes straight
// from mem_read, which is only valid in the cycle the write is presented.
module video_blitter
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DIM_LOG2   = 7
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_base,
  input  logic [ADDR_WIDTH-1:0] cmd_src_base,
  input  logic [DIM_LOG2-1:0]   cmd_x,
  input  logic [DIM_LOG2-1:0]   cmd_y,
  input  logic [DIM_LOG2-1:0]   cmd_sx,
  input  logic [DIM_LOG2-1:0]   cmd_sy,
  input  logic [7:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [23:0]           cmd_color,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [31:0]           mem_write,
  input  logic [31:0]           mem_read
);

  blit_state_t           state;
  blit_state_t           state_next;
  blit_op_t              op;

  logic [ADDR_WIDTH-1:0] dst_base_q;
  logic [ADDR_WIDTH-1:0] src_base_q;
  logic [DIM_LOG2-1:0]   x_q;
  logic [DIM_LOG2-1:0]   y_q;
  logic [DIM_LOG2-1:0]   sx_q;
  logic [DIM_LOG2-1:0]   sy_q;
  logic [23:0]           color_q;

  logic                  mem_en_q;
  logic [3:0]            mem_we_q;
  logic [31:0]           mem_write_q;
  logic                  copy_wr_q;
  logic                  key_skip;

  logic                  accept;
  logic [7:0]            ew_dst;
  logic [7:0]            eh_dst;
  logic [7:0]            ew_load;
  logic [7:0]            eh_load;
  logic                  rect_empty;

  logic [7:0]            col;
  logic [7:0]            row;
  logic                  last;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] src_addr;

  assign op     = blit_op_t'(cmd_op);
  assign accept = cmd_valid && cmd_ready && (state == ST_IDLE);

  // Clip the incoming rectangle against the destination edge, and for COPY also the source edge.
  always_comb begin
    ew_dst  = clip_extent(cmd_w, cmd_x);
    eh_dst  = clip_extent(cmd_h, cmd_y);
    ew_load = ew_dst;
    eh_load = eh_dst;
    if (op == OP_COPY) begin
      ew_load = clip_extent(ew_dst, cmd_sx);
      eh_load = clip_extent(eh_dst, cmd_sy);
    end
    rect_empty = (ew_load == 8'd0) || (eh_load == 8'd0);
  end

  rect_scanner u_scanner (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance ((state == ST_FILL) || (state == ST_COPY_WR)),
    .ew_in   (ew_load),
    .eh_in   (eh_load),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  // Clipping keeps x+col and y+row inside the frame, so the offset is {y+row, x+col}; the base add wraps.
  assign dst_addr = dst_base_q
                  + (((ADDR_WIDTH'(y_q) + ADDR_WIDTH'(row)) << DIM_LOG2)
                     + ADDR_WIDTH'(x_q) + ADDR_WIDTH'(col));
  assign src_addr = src_base_q
                  + (((ADDR_WIDTH'(sy_q) + ADDR_WIDTH'(row)) << DIM_LOG2)
                     + ADDR_WIDTH'(sx_q) + ADDR_WIDTH'(col));

  // Capture the command fields on the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_base_q <= '0;
      src_base_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      color_q    <= 24'd0;
    end else if (accept) begin
      dst_base_q <= cmd_dst_base;
      src_base_q <= cmd_src_base;
      x_q        <= cmd_x;
      y_q        <= cmd_y;
      sx_q       <= cmd_sx;
      sy_q       <= cmd_sy;
      color_q    <= cmd_color;
    end
  end

  // Next-state selection: empty rectangles and the reserved op go straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_FILL: state_next = rect_empty ? ST_DONE : ST_FILL;
            OP_COPY: state_next = rect_empty ? ST_DONE : ST_COPY_RD;
            OP_FLIP: state_next = ST_FLIP;
            default: state_next = ST_DONE;
          endcase
        end
      end
      ST_FILL:    state_next = last ? ST_DONE : ST_FILL;
      ST_COPY_RD: state_next = ST_COPY_WR;
      ST_COPY_WR: state_next = last ? ST_DONE : ST_COPY_RD;
      ST_FLIP:    state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Register the bus cycle and handshake outputs for the state the FSM is in now.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr    <= '0;
      mem_write_q <= 32'd0;
      copy_wr_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 4'h0;
      copy_wr_q <= 1'b0;
      done      <= (state == ST_DONE);
      busy      <= (state_next != ST_IDLE);
      cmd_ready <= (state_next == ST_IDLE);
      case (state)
        ST_FILL: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= 4'hF;
          mem_addr    <= {1'b0, dst_addr};
          mem_write_q <= {8'd0, color_q};
        end
        ST_COPY_RD: begin
          mem_en_q <= 1'b1;
          mem_addr <= {1'b0, src_addr};
        end
        ST_COPY_WR: begin
          mem_en_q  <= 1'b1;
          mem_we_q  <= 4'hF;
          mem_addr  <= {1'b0, dst_addr};
          copy_wr_q <= 1'b1;
        end
        ST_FLIP: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= 4'hF;
          mem_addr    <= CR_BASE_ADDR;
          mem_write_q <= 32'(dst_base_q);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef VIDEO_BLITTER_COLORKEY_EN
  assign key_skip = copy_wr_q && (mem_read[23:0] == color_q);
`else
  assign key_skip = 1'b0;
`endif

  assign mem_en    = mem_en_q && !key_skip;
  assign mem_we    = key_skip ? 4'h0 : mem_we_q;
  assign mem_write = copy_wr_q ? mem_read : mem_write_q;

endmodule
